// File: rtl/dyn_mod_counter.sv
// Runtime-modulus counter: modulus and direction are latched at Start and at each
// wrap, with start/stop control, count-enable qualifier and one-shot mode.
module dyn_mod_counter #(
  parameter int NBBITS = 8
) (
  input  logic              Clk,
  input  logic              aReset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              En,
  input  logic              OneShot,
  input  logic              Dir,
  input  logic [NBBITS-1:0] Mod,
  output logic [NBBITS-1:0] Q,
  output logic              Busy,
  output logic              Tc,
  output logic              Wrap,
  output logic              Done
);

  localparam logic [NBBITS:0] FULL_RANGE = {1'b1, {NBBITS{1'b0}}};

  logic [NBBITS-1:0] mod_reg;
  logic              dir_reg;
  logic              os_reg;
  logic [NBBITS:0]   eff_mod;
  logic [NBBITS:0]   eff_last;
  logic [NBBITS-1:0] term_val;
  logic              at_term;

  // Start value for a given modulus/direction: 0 counting up, M-1 counting down.
  function automatic logic [NBBITS-1:0] start_of(input logic [NBBITS-1:0] m,
                                                 input logic              d);
    logic [NBBITS:0] full;
    full = (m == '0) ? FULL_RANGE : {1'b0, m};
    full = full - 1'b1;
    return d ? '0 : full[NBBITS-1:0];
  endfunction

  assign eff_mod  = (mod_reg == '0) ? FULL_RANGE : {1'b0, mod_reg};
  assign eff_last = eff_mod - 1'b1;
  assign term_val = dir_reg ? eff_last[NBBITS-1:0] : '0;
  assign at_term  = (Q == term_val);
  assign Tc       = Busy & at_term;

  always_ff @(posedge Clk or negedge aReset) begin
    if (!aReset) begin
      Q       <= '0;
      Busy    <= 1'b0;
      Wrap    <= 1'b0;
      Done    <= 1'b0;
      mod_reg <= '0;
      dir_reg <= 1'b1;
      os_reg  <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      Done <= 1'b0;
      if (Stop) begin
        Busy <= 1'b0;
      end else if (Start) begin
        mod_reg <= Mod;
        dir_reg <= Dir;
        os_reg  <= OneShot;
        Q       <= start_of(Mod, Dir);
        Busy    <= 1'b1;
      end else if (Busy && En) begin
        if (!at_term) begin
          Q <= dir_reg ? Q + 1'b1 : Q - 1'b1;
        end else begin
          Wrap <= 1'b1;
          // One-shot keeps the latched modulus/direction so Q parks on its own start value.
          if (os_reg) begin
            Busy <= 1'b0;
            Done <= 1'b1;
            Q    <= start_of(mod_reg, dir_reg);
          end else begin
            mod_reg <= Mod;
            dir_reg <= Dir;
            Q       <= start_of(Mod, Dir);
          end
        end
      end
    end
  end

endmodule

// File: doc/dyn_mod_counter.md
# dyn_mod_counter

Runtime-modulus counter with latched modulus and direction, start/stop control, a count-enable qualifier and a one-shot mode. It replaces the fixed-behaviour modulo-N counters in the WS2812 bit-timing and reset-gap paths. The modulus is taken only at Start and at wrap, so Mod may change mid-period without glitching Q. Wrap, Done and terminal-count flags drive sequencing FSMs directly.

## Interface
- NBBITS, 8, counter and modulus width
- Clk  in  1  clock; all state changes on rising edge
- aReset  in  1  asynchronous reset, active-low
- Start  in  1  sync: latch Mod/Dir, load start value, set Busy
- Stop  in  1  sync: clear Busy, hold Q
- En  in  1  count qualifier (prescaler tick); counts only when Busy=1
- OneShot  in  1  1 = stop after one full period; sampled at Start
- Dir  in  1  1 = up, 0 = down; sampled at Start and at each wrap
- Mod  in  NBBITS  modulus; 0 means 2^NBBITS; sampled at Start and at each wrap
- Q  out  NBBITS  count value
- Busy  out  1  counter running
- Tc  out  1  combinational: Busy & (Q == terminal value)
- Wrap  out  1  registered 1-cycle pulse on each period completion
- Done  out  1  registered 1-cycle pulse when a one-shot period completes

## Operation
- Internal registers: ModReg (NBBITS), DirReg, OsReg.
- Effective modulus M = (ModReg == 0) ? 2^NBBITS : ModReg. Compute in NBBITS+1 bits; never use the % operator.
- Start value: 0 if DirReg=1, M-1 if DirReg=0.
- Terminal value: M-1 if DirReg=1, 0 if DirReg=0.
- Per-edge priority, highest first:
  - Stop=1: Busy<=0; Q, ModReg and DirReg hold. Stop wins over a simultaneous Start.
  - Start=1: ModReg<=Mod, DirReg<=Dir, OsReg<=OneShot. Q<=start value computed from the new Mod/Dir. Busy<=1. Restarts a running counter.
  - Busy=1 & En=1 & Q≠terminal: Q<=Q+1 (up) or Q-1 (down).
  - Busy=1 & En=1 & Q=terminal: wrap.
    - Wrap<=1.
    - ModReg<=Mod and DirReg<=Dir, except in one-shot, where both hold.
    - Q<=start value computed from the new ModReg/DirReg.
    - If OsReg=1: Busy<=0, Done<=1, and Q<=start value of the held ModReg/DirReg.
  - Otherwise: hold.
- Wrap and Done are 0 on every edge not listed above.
- M=1: Q stays 0, and Wrap pulses on every enabled edge.
- Q never leaves [0, M-1] for the currently latched M.

## Timing
- Reset (aReset=0, asynchronous): Q=0, Busy=0, Wrap=0, Done=0, ModReg=0, DirReg=1, OsReg=0.
- Start at edge k: Q=start value and Busy=1 after k. First count possible at k+1.
- Up, M=5, En always 1, Start at edge 0: Q after edges 0..6 = 0,1,2,3,4,0,1. Wrap is high in the cycle after edge 5.
- Tc is high during the cycle before the wrapping edge. Wrap is high during the cycle after it.
- A Mod change mid-period takes effect only after the next wrap or Start.
- En=0 while Busy: Q, Tc hold; no Wrap.
- Stop then Start: Start reloads the start value; the old count is not resumed.
- Reset mid-count: all outputs return to reset values immediately. The next Start behaves as from power-up.

## Test plan
- Reset; Start with Mod=5, Dir=1, OneShot=0, En=1 → Q=0,1,2,3,4,0,…; Tc while Q=4; Wrap pulse every 5 cycles; Busy stays 1.
- Start with Mod=4, Dir=0, OneShot=1 → Q=3,2,1,0,3; Wrap and Done each pulse once; Busy=0 afterwards; Q holds 3 with En=1.
- Running up with Mod=6; change Mod to 3 at Q=2 → Q continues 3,4,5,0; then 0,1,2,0 with period 3.
- Mod=0, NBBITS=4, up → Q counts 0..15 then 0; Wrap on the 15→0 edge. Mod=1 → Q=0 constantly, Wrap every enabled cycle.
- En toggled 1/0 every cycle with Mod=3 → Q advances every second cycle; Wrap only on enabled edges.
- Start+Stop in the same cycle → Busy=0 and Q unchanged. Assert aReset low mid-count (async, between edges) → Q=0, Busy=0 immediately.
